// File: rtl/light_seq_pkg.sv
// rtl/light_seq_pkg.sv - shared state encoding, widths and light decode for light_sequencer
// Contents:
//    STATE_W, TIMER_W   widths of the state code and the dwell timer
//    state_e            sequencer state encoding (code appears on port state)
//    lights_for()       {green, yellow, red} drive for a given state
package light_seq_pkg;

   localparam int STATE_W = 3;
   localparam int TIMER_W = 6;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_GREEN    = 3'd1,
      ST_YELLOW   = 3'd2,
      ST_RED      = 3'd3,
      ST_LOCKDOWN = 3'd4
   } state_e;

   // LOCKDOWN shows red; IDLE and unused codes show nothing.
   function automatic logic [2:0] lights_for(state_e st);
      logic [2:0] l;
      l = 3'b000;
      case (st)
         ST_GREEN:    l = 3'b100;
         ST_YELLOW:   l = 3'b010;
         ST_RED:      l = 3'b001;
         ST_LOCKDOWN: l = 3'b001;
         default:     l = 3'b000;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - loadable down-counter holding the remaining dwell minus one
// Ports:
//    clock       in   system clock, rising edge
//    reset_n     in   asynchronous active-low reset, clears count
//    load_i      in   load load_val_i (has priority over decrement)
//    load_val_i  in   TIMER_W value to load
//    dec_i       in   decrement by one; holds at zero rather than wrapping
//    count_o     out  registered count
//    zero_o      out  count_o == 0
module dwell_counter
   import light_seq_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic [TIMER_W-1:0] count_o,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - traffic-light style sequencer with alarm lockdown and cheat detection
// Optional feature: define LIGHT_SEQ_PAUSE_EN to add input pause, which freezes
// timer and state while high (alarms still force LOCKDOWN).
// Ports:
//    clock        in   system clock, rising edge
//    reset_n      in   asynchronous active-low reset
//    pause        in   (LIGHT_SEQ_PAUSE_EN only) hold timer and state
//    a1, a2, a3   in   alarm flags; any high forces LOCKDOWN
//    cheat_out    in   cheat flag; rising edge forces RED and is counted
//    green        out  registered light drive
//    yellow       out  registered light drive
//    red          out  registered light drive (also high in LOCKDOWN)
//    timer        out  remaining dwell cycles minus one
//    state        out  current state code
//    cheat_count  out  saturating count of cheat_out rising edges
module light_sequencer
   import light_seq_pkg::*;
#(
   parameter int GREEN_TIME  = 35,
   parameter int YELLOW_TIME = 6,
   parameter int RED_TIME    = 25,
   parameter int CLEAR_TIME  = 10
) (
   input  logic               clock,
   input  logic               reset_n,
`ifdef LIGHT_SEQ_PAUSE_EN
   input  logic               pause,
`endif
   input  logic               a1,
   input  logic               a2,
   input  logic               a3,
   input  logic               cheat_out,
   output logic               green,
   output logic               yellow,
   output logic               red,
   output logic [TIMER_W-1:0] timer,
   output logic [STATE_W-1:0] state,
   output logic [3:0]         cheat_count
);

   localparam logic [TIMER_W-1:0] GREEN_V  = TIMER_W'(GREEN_TIME - 1);
   localparam logic [TIMER_W-1:0] YELLOW_V = TIMER_W'(YELLOW_TIME - 1);
   localparam logic [TIMER_W-1:0] RED_V    = TIMER_W'(RED_TIME - 1);
   localparam logic [TIMER_W-1:0] CLEAR_V  = TIMER_W'(CLEAR_TIME - 1);

   state_e             state_q;
   state_e             state_d;
   logic [2:0]         lights_q;
   logic [2:0]         lights_d;
   logic               cheat_prev_q;
   logic [3:0]         cheat_count_q;
   logic [3:0]         cheat_count_d;

   logic               pause_w;
   logic               alarm;
   logic               cheat_edge;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_load_val;
   logic               tmr_dec;
   logic               tmr_zero;

`ifdef LIGHT_SEQ_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   assign alarm      = a1 | a2 | a3;
   assign cheat_edge = cheat_out & ~cheat_prev_q;

   // Priority inside the running states: alarm, then pause, then cheat edge,
   // then timer expiry. Alarms still get through a pause.
   always_comb begin
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d      = ST_GREEN;
            tmr_load     = 1'b1;
            tmr_load_val = GREEN_V;
         end
         ST_GREEN, ST_YELLOW, ST_RED: begin
            if (alarm) begin
               state_d      = ST_LOCKDOWN;
               tmr_load     = 1'b1;
               tmr_load_val = CLEAR_V;
            end else if (pause_w) begin
               state_d = state_q;
            end else if (cheat_edge) begin
               // Also restarts the dwell when already in RED.
               state_d      = ST_RED;
               tmr_load     = 1'b1;
               tmr_load_val = RED_V;
            end else if (tmr_zero) begin
               tmr_load = 1'b1;
               case (state_q)
                  ST_GREEN: begin
                     state_d      = ST_YELLOW;
                     tmr_load_val = YELLOW_V;
                  end
                  ST_YELLOW: begin
                     state_d      = ST_RED;
                     tmr_load_val = RED_V;
                  end
                  default: begin
                     state_d      = ST_GREEN;
                     tmr_load_val = GREEN_V;
                  end
               endcase
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_LOCKDOWN: begin
            // Any alarm restarts the clear window; exit needs CLEAR_TIME quiet cycles.
            if (alarm) begin
               tmr_load     = 1'b1;
               tmr_load_val = CLEAR_V;
            end else if (pause_w) begin
               state_d = state_q;
            end else if (tmr_zero) begin
               state_d      = ST_GREEN;
               tmr_load     = 1'b1;
               tmr_load_val = GREEN_V;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      cheat_count_d = cheat_count_q;
      if (cheat_edge && (state_q != ST_IDLE) && (cheat_count_q != 4'hF)) begin
         cheat_count_d = cheat_count_q + 4'd1;
      end
   end

   assign lights_d = lights_for(state_d);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         lights_q      <= 3'b000;
         cheat_prev_q  <= 1'b0;
         cheat_count_q <= 4'd0;
      end else begin
         state_q       <= state_d;
         lights_q      <= lights_d;
         cheat_prev_q  <= cheat_out;
         cheat_count_q <= cheat_count_d;
      end
   end

   dwell_counter u_dwell_counter (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .dec_i      (tmr_dec),
      .count_o    (timer),
      .zero_o     (tmr_zero)
   );

   assign state       = state_q;
   assign green       = lights_q[2];
   assign yellow      = lights_q[1];
   assign red         = lights_q[0];
   assign cheat_count = cheat_count_q;

endmodule

// File: tb/tb_light_sequencer.sv
// tb/tb_light_sequencer.sv - directed self-checking bench for light_sequencer (default parameters)
module tb_light_sequencer;

   logic       clock;
   logic       reset_n;
   logic       a1, a2, a3;
   logic       cheat_out;
   logic       green, yellow, red;
   logic [5:0] timer;
   logic [2:0] state;
   logic [3:0] cheat_count;

   int total = 0;
   int bad   = 0;

   light_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .a1          (a1),
      .a2          (a2),
      .a3          (a3),
      .cheat_out   (cheat_out),
      .green       (green),
      .yellow      (yellow),
      .red         (red),
      .timer       (timer),
      .state       (state),
      .cheat_count (cheat_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic [2:0] lt,
                          input logic [5:0] tm);
      chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
      chk({tag, ".lights"}, {5'd0, green, yellow, red}, {5'd0, lt});
      chk({tag, ".timer"}, {2'd0, timer}, {2'd0, tm});
   endtask

   initial begin
      reset_n = 1'b0; a1 = 0; a2 = 0; a3 = 0; cheat_out = 0;
      step(3);
      chk_all("reset", 3'd0, 3'b000, 6'd0);
      chk("reset.cnt", {4'd0, cheat_count}, 8'd0);

      // Release: GREEN on the first edge, then full cycle 35/6/25.
      reset_n = 1'b1;
      step(1);
      for (int i = 0; i < 35; i++) begin chk_all("green", 3'd1, 3'b100, 6'(34 - i)); step(1); end
      for (int i = 0; i < 6; i++)  begin chk_all("yellow", 3'd2, 3'b010, 6'(5 - i)); step(1); end
      for (int i = 0; i < 25; i++) begin chk_all("red", 3'd3, 3'b001, 6'(24 - i)); step(1); end
      chk_all("wrap", 3'd1, 3'b100, 6'd34);

      // One-cycle a2 pulse mid-GREEN.
      step(5);
      chk_all("pre_a2", 3'd1, 3'b100, 6'd29);
      a2 = 1; step(1); a2 = 0;
      for (int i = 0; i < 10; i++) begin chk_all("lock_a2", 3'd4, 3'b001, 6'(9 - i)); step(1); end
      chk_all("exit_a2", 3'd1, 3'b100, 6'd34);

      // a1 held: timer stuck at 9.
      a1 = 1;
      for (int i = 0; i < 20; i++) begin step(1); chk_all("lock_a1", 3'd4, 3'b001, 6'd9); end
      a1 = 0;
      for (int i = 1; i < 10; i++) begin step(1); chk_all("drain_a1", 3'd4, 3'b001, 6'(9 - i)); end
      step(1);
      chk_all("exit_a1", 3'd1, 3'b100, 6'd34);

      // Cheat edge in YELLOW.
      step(35);
      chk_all("to_yellow", 3'd2, 3'b010, 6'd5);
      cheat_out = 1; step(1);
      chk_all("cheat_y", 3'd3, 3'b001, 6'd24);
      chk("cheat_y.cnt", {4'd0, cheat_count}, 8'd1);
      step(5);
      chk_all("cheat_hold", 3'd3, 3'b001, 6'd19);
      chk("cheat_hold.cnt", {4'd0, cheat_count}, 8'd1);
      cheat_out = 0; step(1);
      chk_all("cheat_low", 3'd3, 3'b001, 6'd18);

      // Cheat edge in RED restarts the dwell.
      cheat_out = 1; step(1); cheat_out = 0;
      chk_all("cheat_r", 3'd3, 3'b001, 6'd24);
      chk("cheat_r.cnt", {4'd0, cheat_count}, 8'd2);
      step(1);

      // Alarm beats a coincident cheat edge; edge still counted.
      a3 = 1; cheat_out = 1; step(1); a3 = 0; cheat_out = 0;
      chk_all("a3_cheat", 3'd4, 3'b001, 6'd9);
      chk("a3_cheat.cnt", {4'd0, cheat_count}, 8'd3);
      step(1);

      // 16 more edges: count saturates at 15.
      for (int i = 0; i < 16; i++) begin
         cheat_out = 1; step(1); cheat_out = 0; step(1);
         chk("sat.cnt", {4'd0, cheat_count}, (3 + i + 1 > 15) ? 8'd15 : 8'(3 + i + 1));
      end

      // Reset during LOCKDOWN.
      a1 = 1; step(1); a1 = 0;
      chk_all("pre_rst", 3'd4, 3'b001, 6'd9);
      reset_n = 1'b0; #1;
      chk_all("async_rst", 3'd0, 3'b000, 6'd0);
      chk("async_rst.cnt", {4'd0, cheat_count}, 8'd0);
      step(1);
      reset_n = 1'b1; step(1);
      chk_all("post_rst", 3'd1, 3'b100, 6'd34);
      chk("post_rst.cnt", {4'd0, cheat_count}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 SHALL have parameter GREEN_TIME, default 35, green dwell in clock cycles (1..63).
REQ-002 SHALL have parameter YELLOW_TIME, default 6, yellow dwell in clock cycles (1..63).
REQ-003 SHALL have parameter RED_TIME, default 25, red dwell in clock cycles (1..63).
REQ-004 SHALL have parameter CLEAR_TIME, default 10, alarm-free cycles required to leave lockdown (1..63).
REQ-005 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports a1, a2, a3  input  1 each  alarm flags returned by the containment FSM.
REQ-008 SHALL have port cheat_out  input  1  cheat flag returned by the containment FSM.
REQ-009 SHALL have ports green, yellow, red  output  1 each  light drive to the containment FSM, registered.
REQ-010 SHALL have port timer  output  6  remaining dwell cycles minus one, registered.
REQ-011 SHALL have port state  output  3  current state code, registered.
REQ-012 SHALL have port cheat_count  output  4  number of cheat_out rising edges seen, saturating.

Function
REQ-013 SHALL implement states IDLE=0, GREEN=1, YELLOW=2, RED=3, LOCKDOWN=4, codes as given on port state.
REQ-014 SHALL drive all lights 0 in IDLE and exactly one light high in every other state (LOCKDOWN drives red).
REQ-015 SHALL leave IDLE for GREEN on the first clock edge after reset_n deasserts.
REQ-016 SHALL load timer with DWELL-1 on entry to GREEN, YELLOW, RED and LOCKDOWN, and decrement it by 1 each cycle otherwise.
REQ-017 SHALL transition GREEN->YELLOW->RED->GREEN when timer==0, so each light is high for exactly its dwell parameter in cycles.
REQ-018 SHALL enter LOCKDOWN on the next edge whenever (a1|a2|a3)==1 is sampled in GREEN, YELLOW or RED.
REQ-019 SHALL reload timer with CLEAR_TIME-1 every cycle in LOCKDOWN while any alarm is high.
REQ-020 SHALL move LOCKDOWN->GREEN when timer==0 with all alarms low, i.e. after CLEAR_TIME consecutive alarm-free cycles.
REQ-021 SHALL detect a cheat_out rising edge (current 1, previous sample 0) and, when not in LOCKDOWN, enter RED with timer reload to RED_TIME-1.
REQ-022 SHALL increment cheat_count on every detected rising edge, in any non-IDLE state, saturating at 15.
REQ-023 SHALL apply priority alarm > cheat edge > timer expiry when events coincide in the same cycle.
REQ-024 SHALL, on a cheat edge while already in RED, restart the RED dwell from RED_TIME-1.
REQ-025 SHALL never wrap timer below 0; it is reloaded before reaching underflow.

Reset
REQ-026 SHALL, while reset_n==0, force state=IDLE, green=yellow=red=0, timer=0, cheat_count=0, cheat edge history=0.
REQ-027 SHALL abort any dwell or lockdown immediately on reset assertion mid-operation, with no residual lockdown after release.

Configuration
REQ-028 SHALL, when LIGHT_SEQ_PAUSE_EN is defined, add input pause (1 bit) that freezes timer and state while high, alarms still forcing LOCKDOWN.
REQ-029 SHALL, when LIGHT_SEQ_PAUSE_EN is undefined, have no pause port and behave as if pause were constantly 0.

Structure
REQ-030 SHALL place the state enum, its 3-bit width and the 6-bit timer width in shared package light_seq_pkg.
REQ-031 SHALL use one sub-module, dwell_counter (load, load value, decrement, zero flag), instanced once.

Verification
REQ-032 Reset release, no alarms -> green=1 for 35 cycles, yellow=1 for 6, red=1 for 25, back to green; timer 34..0 in GREEN.
REQ-033 a2 pulsed high 1 cycle mid-GREEN -> next cycle state=4, red=1; green returns exactly 10 cycles after alarm drop.
REQ-034 a1 held 20 cycles in LOCKDOWN -> timer stuck at 9 throughout; exit 10 cycles after release.
REQ-035 cheat_out 0->1 in YELLOW -> next cycle red=1, timer=24, cheat_count=1; held high 5 cycles -> count stays 1.
REQ-036 a3 and cheat edge in same cycle -> LOCKDOWN entered, cheat_count still increments; 16 cheat edges -> cheat_count=15.
REQ-037 reset_n low for 1 cycle during LOCKDOWN -> all outputs 0 at once; GREEN one cycle after release.
